ecc_fault_manager: RTL and testbench

- Parametrised successor to the pipeline's raw error outputs (s_err/d_err per memory, ALU hardware fault flag).
- Aggregates single- and double-error pulses from N_CH ECC-protected channels plus the spare-ALU fault.
- Keeps per-channel leaky-bucket error counters and per-channel health state machines, then raises an interrupt and a halt request.
- Sits beside the pipeline top; the host clears it through a req/ack handshake.

---
 rtl/ecc_fault_manager.sv | 176 +++++++++++++++++
 tb/tb_ecc_fault_manager.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_fault_manager.sv
// ecc_fault_manager
//   Aggregates ECC single/double error pulses from N_CH channels and the
//   spare-ALU fault flag. Each channel has a leaky-bucket single-error counter
//   and a health FSM (OK / DEGRADED / FAILED). Raises irq on any upward
//   severity change and halt_req while any channel is FAILED or the ALU fault
//   is latched. The host clears channels through a clr_req/clr_ack handshake.
//
// Handshake: clr_req is level, held by the host until it sees clr_ack. A clear
//   is taken on a rising edge of clr_req (clr_req=1 while the previous sampled
//   clr_req was 0); clr_ack pulses for exactly one cycle after it is applied.
//   A held clr_req never triggers a second clear.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_err, d_err      per-channel single / double error pulses
//   alu_fault         spare-ALU checker fault flag
//   clr_req, clr_mask clear request and channel mask (bit N_CH = ALU sticky)
//   clr_ack           one-cycle clear acknowledge
//   se_count          packed single-error counters, channel i at [i*CNT_W +: CNT_W]
//   ch_state          packed channel states, 00=OK 01=DEGRADED 10=FAILED
//   alu_fault_sticky  latched alu_fault
//   first_fail_ch/vld index of the first channel to reach FAILED
//   irq               one-cycle pulse on any upward severity change
//   halt_req          any channel FAILED or ALU fault latched
module ecc_fault_manager #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int SE_THRESH  = 16,
  parameter int WIN_CYCLES = 1024,
  localparam int FF_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       s_err,
  input  logic [N_CH-1:0]       d_err,
  input  logic                  alu_fault,
  input  logic                  clr_req,
  input  logic [N_CH:0]         clr_mask,
  output logic                  clr_ack,
  output logic [N_CH*CNT_W-1:0] se_count,
  output logic [2*N_CH-1:0]     ch_state,
  output logic                  alu_fault_sticky,
  output logic [FF_W-1:0]       first_fail_ch,
  output logic                  first_fail_vld,
  output logic                  irq,
  output logic                  halt_req
);

  localparam int               WIN_W   = $clog2(WIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(SE_THRESH);

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_DEG  = 2'b01,
    ST_FAIL = 2'b10
  } ch_state_e;

  logic [WIN_W-1:0] win_q;
  logic             req_seen_q;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_n [N_CH];
  ch_state_e        st_q  [N_CH];
  ch_state_e        st_n  [N_CH];

  logic             leak;
  logic             clr_fire;
  logic             clr_ch;
  logic [CNT_W-1:0] base;
  ch_state_e        cur;
  logic             any_fail_n;
  logic             up_n;
  logic             new_found;
  logic [FF_W-1:0]  new_idx;
  logic             sticky_n;
  logic             ffv_n;
  logic [FF_W-1:0]  ffc_n;

  always_comb begin
    leak       = (win_q == WIN_W'(WIN_CYCLES - 1));
    clr_fire   = clr_req && !req_seen_q;
    clr_ch     = 1'b0;
    base       = '0;
    cur        = ST_OK;
    any_fail_n = 1'b0;
    up_n       = 1'b0;
    new_found  = 1'b0;
    new_idx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      clr_ch = clr_fire && clr_mask[i];
      base   = clr_ch ? '0 : cnt_q[i];
      // s_err and leak together cancel; otherwise saturate at both ends.
      cnt_n[i] = base;
      if (s_err[i] && !leak) begin
        if (base != CNT_MAX) cnt_n[i] = base + CNT_W'(1);
      end else if (leak && !s_err[i]) begin
        if (base != '0) cnt_n[i] = base - CNT_W'(1);
      end

      // A cleared channel restarts from OK with the cleared count.
      cur      = clr_ch ? ST_OK : st_q[i];
      st_n[i]  = cur;
      case (cur)
        ST_OK: begin
          if (d_err[i])               st_n[i] = ST_FAIL;
          else if (cnt_n[i] >= THRESH) st_n[i] = ST_DEG;
        end
        ST_DEG: begin
          if (d_err[i])               st_n[i] = ST_FAIL;
          else if (cnt_n[i] == '0)    st_n[i] = ST_OK;
        end
        default: st_n[i] = ST_FAIL;
      endcase

      if (2'(st_n[i]) > 2'(st_q[i])) up_n = 1'b1;
      if (st_n[i] == ST_FAIL) begin
        any_fail_n = 1'b1;
        // Ascending scan: the lowest newly-failing index is kept.
        if (st_q[i] != ST_FAIL && !new_found) begin
          new_found = 1'b1;
          new_idx   = FF_W'(i);
        end
      end
    end

    sticky_n = alu_fault || (alu_fault_sticky && !(clr_fire && clr_mask[N_CH]));

    ffv_n = first_fail_vld;
    ffc_n = first_fail_ch;
    if (!first_fail_vld && new_found) begin
      ffv_n = 1'b1;
      ffc_n = new_idx;
    end else if (first_fail_vld && clr_fire && !any_fail_n) begin
      ffv_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q            <= '0;
      req_seen_q       <= 1'b0;
      clr_ack          <= 1'b0;
      alu_fault_sticky <= 1'b0;
      first_fail_ch    <= '0;
      first_fail_vld   <= 1'b0;
      irq              <= 1'b0;
      halt_req         <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        st_q[i]  <= ST_OK;
      end
    end else begin
      win_q            <= leak ? '0 : win_q + WIN_W'(1);
      req_seen_q       <= clr_req;
      clr_ack          <= clr_fire;
      alu_fault_sticky <= sticky_n;
      first_fail_ch    <= ffc_n;
      first_fail_vld   <= ffv_n;
      irq              <= up_n || (sticky_n && !alu_fault_sticky);
      halt_req         <= any_fail_n || sticky_n;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_n[i];
        st_q[i]  <= st_n[i];
      end
    end
  end

  // Pure wiring of the state registers onto the packed outputs.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      se_count[i*CNT_W +: CNT_W] = cnt_q[i];
      ch_state[2*i +: 2]         = st_q[i];
    end
  end

endmodule

// File: tb/tb_ecc_fault_manager.sv
// Testbench for ecc_fault_manager (N_CH=4, CNT_W=4, SE_THRESH=4, WIN_CYCLES=16).
// Every cycle is checked against a behavioural model through an expected
// queue; a directed table and hand-written sequences add constant checks.
module tb_ecc_fault_manager;

  localparam int N_CH       = 4;
  localparam int CNT_W      = 4;
  localparam int SE_THRESH  = 4;
  localparam int WIN_CYCLES = 16;
  localparam int CNT_MAX    = 15;
  localparam int OUT_W      = 31;

  logic        clk;
  logic        rst;
  logic [3:0]  s_err;
  logic [3:0]  d_err;
  logic        alu_fault;
  logic        clr_req;
  logic [4:0]  clr_mask;
  logic        clr_ack;
  logic [15:0] se_count;
  logic [7:0]  ch_state;
  logic        alu_fault_sticky;
  logic [1:0]  first_fail_ch;
  logic        first_fail_vld;
  logic        irq;
  logic        halt_req;

  int checks = 0;
  int errors = 0;

  ecc_fault_manager #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SE_THRESH(SE_THRESH), .WIN_CYCLES(WIN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .s_err(s_err), .d_err(d_err), .alu_fault(alu_fault),
    .clr_req(clr_req), .clr_mask(clr_mask), .clr_ack(clr_ack),
    .se_count(se_count), .ch_state(ch_state), .alu_fault_sticky(alu_fault_sticky),
    .first_fail_ch(first_fail_ch), .first_fail_vld(first_fail_vld),
    .irq(irq), .halt_req(halt_req)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_cnt [N_CH];
  int   m_st  [N_CH];   // severity 0=OK 1=DEGRADED 2=FAILED
  bit   m_sticky, m_ffv, m_irq, m_halt, m_ack, m_prev_req;
  int   m_ffc;
  int   m_win;
  logic [OUT_W-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_cnt[i] = 0;
      m_st[i]  = 0;
    end
    m_sticky = 0; m_ffv = 0; m_irq = 0; m_halt = 0; m_ack = 0; m_prev_req = 0;
    m_ffc = 0; m_win = 0;
    exp_q.delete();
  endtask

  function automatic logic [OUT_W-1:0] model_vec();
    logic [15:0] c;
    logic [7:0]  s;
    for (int i = 0; i < N_CH; i++) begin
      c[i*4 +: 4] = 4'(m_cnt[i]);
      s[i*2 +: 2] = 2'(m_st[i]);
    end
    return {m_ack, c, s, m_sticky, (m_ffv ? 2'(m_ffc) : 2'b00), m_ffv, m_irq, m_halt};
  endfunction

  function automatic logic [OUT_W-1:0] dut_vec();
    return {clr_ack, se_count, ch_state, alu_fault_sticky,
            (first_fail_vld ? first_fail_ch : 2'b00), first_fail_vld, irq, halt_req};
  endfunction

  // One clock edge of the specification's rules, applied to the sampled inputs.
  task automatic model_step();
    bit leak, fire, clr_i, anyf, up, n_sticky;
    int first, base, nc, from, ns;
    int n_cnt [N_CH];
    int n_st  [N_CH];
    leak  = (m_win == WIN_CYCLES - 1);
    fire  = clr_req && !m_prev_req;
    anyf  = 0;
    up    = 0;
    first = -1;
    for (int i = 0; i < N_CH; i++) begin
      clr_i = fire && clr_mask[i];
      base  = clr_i ? 0 : m_cnt[i];
      nc    = base + int'(s_err[i]) - int'(leak);
      if (nc < 0) nc = 0;
      if (nc > CNT_MAX) nc = CNT_MAX;
      from = clr_i ? 0 : m_st[i];
      ns   = from;
      if (from != 2) begin
        if (d_err[i]) ns = 2;
        else if (from == 0 && nc >= SE_THRESH) ns = 1;
        else if (from == 1 && nc == 0) ns = 0;
      end
      if (ns > m_st[i]) up = 1;
      if (ns == 2) anyf = 1;
      if (ns == 2 && m_st[i] != 2 && first < 0) first = i;
      n_cnt[i] = nc;
      n_st[i]  = ns;
    end
    n_sticky = alu_fault || (m_sticky && !(fire && clr_mask[N_CH]));
    if (!m_ffv && first >= 0) begin
      m_ffv = 1;
      m_ffc = first;
    end else if (m_ffv && fire && !anyf) begin
      m_ffv = 0;
    end
    m_irq      = up || (n_sticky && !m_sticky);
    m_halt     = anyf || n_sticky;
    m_sticky   = n_sticky;
    m_ack      = fire;
    m_prev_req = clr_req;
    m_win      = (m_win + 1) % WIN_CYCLES;
    for (int i = 0; i < N_CH; i++) begin
      m_cnt[i] = n_cnt[i];
      m_st[i]  = n_st[i];
    end
    exp_q.push_back(model_vec());
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [OUT_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL model_queue_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("model", 64'(dut_vec()), 64'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    s_err = '0; d_err = '0; alu_fault = 1'b0; clr_req = 1'b0; clr_mask = '0;
  endtask

  // Inputs are set at a negedge; the edge is modelled, then outputs checked
  // at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int cnt_of(input int ch);
    return int'(se_count[ch*4 +: 4]);
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] s;
    logic [3:0] d;
    logic       alu;
    logic       req;
    logic [4:0] mask;
    logic       ack;
    logic       irq;
    logic       halt;
    logic       stk;
    logic       ffv;
    logic [1:0] ffc;
    logic [7:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] s, input logic [3:0] d, input logic alu,
                     input logic req, input logic [4:0] mask, input logic ack,
                     input logic ir, input logic hl, input logic stk,
                     input logic ffv, input logic [1:0] ffc, input logic [7:0] st);
    vec_t v;
    v.s = s; v.d = d; v.alu = alu; v.req = req; v.mask = mask; v.ack = ack;
    v.irq = ir; v.halt = hl; v.stk = stk; v.ffv = ffv; v.ffc = ffc; v.st = st;
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  int irq_cnt;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check("reset_outputs", 64'(dut_vec()), 64'd0);
    rst = 1'b0;

    //   s      d      alu  req  mask      ack irq hlt stk ffv ffc  state
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 0, 0, 0, 2'd0, 8'h00);
    add(4'h0, 4'h4, 0, 0, 5'b00000,  0, 1, 1, 0, 1, 2'd2, 8'h20);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 1, 0, 1, 2'd2, 8'h20);
    add(4'h0, 4'h8, 0, 0, 5'b00000,  0, 1, 1, 0, 1, 2'd2, 8'hA0);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 1, 0, 1, 2'd2, 8'hA0);
    add(4'h0, 4'h0, 0, 1, 5'b01000,  1, 0, 1, 0, 1, 2'd2, 8'h20);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 1, 0, 1, 2'd2, 8'h20);
    add(4'h0, 4'h4, 0, 1, 5'b00100,  1, 0, 1, 0, 1, 2'd2, 8'h20);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 1, 0, 1, 2'd2, 8'h20);
    add(4'h0, 4'h0, 0, 1, 5'b00100,  1, 0, 0, 0, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 0, 0, 0, 2'd0, 8'h00);
    add(4'h0, 4'hA, 0, 0, 5'b00000,  0, 1, 1, 0, 1, 2'd1, 8'h88);
    add(4'h0, 4'h0, 0, 1, 5'b01010,  1, 0, 0, 0, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 0, 0, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 1, 0, 5'b00000,  0, 1, 1, 1, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 1, 1, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 1, 1, 5'b10000,  1, 0, 1, 1, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 1, 1, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 0, 1, 5'b10000,  1, 0, 0, 0, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 0, 0, 0, 2'd0, 8'h00);
    for (int k = 0; k < 10; k++)
      add(4'h0, 4'h0, 0, 1, 5'b00000, (k == 0), 0, 0, 0, 0, 2'd0, 8'h00);
    add(4'h0, 4'h0, 0, 0, 5'b00000,  0, 0, 0, 0, 0, 2'd0, 8'h00);
    add(4'h1, 4'h1, 0, 0, 5'b00000,  0, 1, 1, 0, 1, 2'd0, 8'h02);
    add(4'h1, 4'h0, 0, 1, 5'b00001,  1, 0, 0, 0, 0, 2'd0, 8'h00);

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      s_err = tbl[r].s; d_err = tbl[r].d; alu_fault = tbl[r].alu;
      clr_req = tbl[r].req; clr_mask = tbl[r].mask;
      cycle();
      check($sformatf("table_row%0d", r),
            64'({clr_ack, irq, halt_req, alu_fault_sticky, first_fail_vld,
                 (tbl[r].ffv ? first_fail_ch : 2'b00), ch_state}),
            64'({tbl[r].ack, tbl[r].irq, tbl[r].halt, tbl[r].stk, tbl[r].ffv,
                 tbl[r].ffc, tbl[r].st}));
    end
    idle_inputs();

    // Leak and hysteresis: leak ticks land on edges 16, 32, 48, 64.
    do_reset();
    irq_cnt = 0;
    for (int k = 1; k <= 64; k++) begin
      s_err = (k <= 4) ? 4'b0010 : 4'b0000;
      cycle();
      irq_cnt += int'(irq);
      if (k == 4) begin
        check("leak_cnt_after_4", 64'(cnt_of(1)), 64'd4);
        check("leak_state_deg", 64'(ch_state[3:2]), 64'd1);
      end
      if (k == 16) check("hyst_state_at_3", 64'({cnt_of(1), 2'(ch_state[3:2])}), 64'({32'd3, 2'd1}));
      if (k == 64) begin
        check("leak_cnt_zero", 64'(cnt_of(1)), 64'd0);
        check("leak_state_ok", 64'(ch_state[3:2]), 64'd0);
      end
    end
    check("leak_irq_once", 64'(irq_cnt), 64'd1);

    // Saturation.
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      s_err = 4'b0001;
      cycle();
      if (k == 20) check("sat_at_20", 64'(cnt_of(0)), 64'd15);
      if (k == 24) check("sat_stays", 64'(cnt_of(0)), 64'd15);
    end

    // s_err on the leak-tick edge (edge 16) with count 7 nets zero.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      s_err = (k <= 7 || k == 16) ? 4'b0001 : 4'b0000;
      cycle();
      if (k == 15) check("collide_pre", 64'(cnt_of(0)), 64'd7);
      if (k == 16) check("collide_tick", 64'(cnt_of(0)), 64'd7);
    end

    // Asynchronous reset mid-operation.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      s_err = 4'b0001;
      d_err = (k == 3) ? 4'b0010 : 4'b0000;
      cycle();
    end
    idle_inputs();
    check("pre_reset_state", 64'({cnt_of(0), 2'(ch_state[3:2]), halt_req}), 64'({32'd9, 2'd2, 1'b1}));
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", 64'(dut_vec()), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      s_err = (k == 1) ? 4'b0100 : 4'b0000;
      cycle();
      if (k == 15) check("win_restart_pre", 64'(cnt_of(2)), 64'd1);
      if (k == 16) check("win_restart_leak", 64'(cnt_of(2)), 64'd0);
    end

    // Randomized phase against the model.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      s_err     = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      d_err     = ($urandom_range(0, 39) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      alu_fault = ($urandom_range(0, 99) == 0);
      if (clr_req) clr_req = ($urandom_range(0, 2) != 0);
      else         clr_req = ($urandom_range(0, 3) == 0);
      clr_mask  = 5'($urandom_range(0, 31));
      cycle();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
